// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and one-hot helper for the register file
//               and any other consumer of the 3-bit address decoder output.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_WIDTH = 3;

    // True when exactly one bit of the 8-bit select is set.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : rf_reg_slice
// Description : One storage register with write enable and async
//               active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_reg_slice #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled; reset clears immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_register_file.sv
`default_nettype none
// ============================================================================
// Module      : onehot_register_file
// Description : 8-entry register file written through a one-hot select,
//               two registered read ports with write-to-read forwarding,
//               and a sticky flag for illegal (non-one-hot) write selects.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_register_file #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = rf_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [NUM_REGS-1:0]   w_sel,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data0,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic                  clr_err,
    output logic                  err_sticky,
    output logic                  wr_ack
);

    import rf_pkg::is_onehot;

    logic                  sel_onehot;
    logic                  wr_legal;
    logic                  wr_illegal;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_next0;
    logic [DATA_WIDTH-1:0] rd_next1;

    // Qualify the write: only a single selected register may be updated.
    always_comb begin
        sel_onehot = is_onehot(w_sel);
        wr_legal   = we && sel_onehot;
        wr_illegal = we && !sel_onehot;
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            rf_reg_slice #(
                .WIDTH (DATA_WIDTH)
            ) u_slice (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (wr_legal && w_sel[i]),
                .d       (w_data),
                .q       (regs[i])
            );
        end
    endgenerate

    // Read mux with forwarding of a same-cycle legal write to the read address.
    always_comb begin
        rd_next0 = regs[rd_addr0];
        rd_next1 = regs[rd_addr1];
        if (wr_legal && w_sel[rd_addr0]) begin
            rd_next0 = w_data;
        end
        if (wr_legal && w_sel[rd_addr1]) begin
            rd_next1 = w_data;
        end
    end

    // Registered read data, write acknowledge and sticky error (set beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data0   <= '0;
            rd_data1   <= '0;
            wr_ack     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            rd_data0 <= rd_next0;
            rd_data1 <= rd_next1;
            wr_ack   <= wr_legal;
            if (wr_illegal) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_register_file
// Description : Directed self-checking bench with an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_register_file;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [7:0]  w_sel;
    logic [31:0] w_data;
    logic [2:0]  rd_addr0;
    logic [2:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic        clr_err;
    logic        err_sticky;
    logic        wr_ack;

    typedef struct {
        string       tag;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        ack;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [8];
    logic        mdl_err;
    int          errors;
    int          checks;

    onehot_register_file dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .w_sel      (w_sel),
        .w_data     (w_data),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_data0   (rd_data0),
        .rd_data1   (rd_data1),
        .clr_err    (clr_err),
        .err_sticky (err_sticky),
        .wr_ack     (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, then compare
    // them just after the capturing edge.
    task automatic step(input logic we_i, input logic [7:0] sel_i, input logic [31:0] data_i,
                        input logic [2:0] a0, input logic [2:0] a1, input logic clr_i,
                        input string tag);
        exp_t e;
        logic legal;
        we = we_i; w_sel = sel_i; w_data = data_i;
        rd_addr0 = a0; rd_addr1 = a1; clr_err = clr_i;
        legal = we_i && ($countones(sel_i) == 1);
        e.tag = tag;
        e.rd0 = (legal && sel_i[a0]) ? data_i : mdl[a0];
        e.rd1 = (legal && sel_i[a1]) ? data_i : mdl[a1];
        e.ack = legal;
        if (we_i && !legal) mdl_err = 1'b1;
        else if (clr_i)     mdl_err = 1'b0;
        e.err = mdl_err;
        for (int i = 0; i < 8; i++) if (legal && sel_i[i]) mdl[i] = data_i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".rd0"}, rd_data0, e.rd0);
            chk({e.tag, ".rd1"}, rd_data1, e.rd1);
            chk({e.tag, ".ack"}, {31'd0, wr_ack}, {31'd0, e.ack});
            chk({e.tag, ".err"}, {31'd0, err_sticky}, {31'd0, e.err});
        end
    endtask

    initial begin
        errors = 0; checks = 0; mdl_err = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        reset_n = 1'b0; we = 1'b0; w_sel = '0; w_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; clr_err = 1'b0;

        // Reset state
        #12;
        chk("reset.rd0", rd_data0, 32'd0);
        chk("reset.rd1", rd_data1, 32'd0);
        chk("reset.ack", {31'd0, wr_ack}, 32'd0);
        chk("reset.err", {31'd0, err_sticky}, 32'd0);
        reset_n = 1'b1;

        // Read every address on both ports after reset
        for (int i = 0; i < 8; i++)
            step(1'b0, 8'h00, 32'd0, 3'(i), 3'(7 - i), 1'b0, "rd_reset");

        // Write each register, reading a different register meanwhile
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'h01 << i, 32'hA000_0000 + 32'(i), 3'(i + 1), 3'(i + 2), 1'b0, "write");
        // Read back each register
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 32'd0, 3'(i), 3'(7 - i), 1'b0, "readback");
            chk("readback.const", rd_data0, 32'hA000_0000 + 32'(i));
        end

        // Forwarding to both ports
        step(1'b1, 8'h20, 32'h1111_1111, 3'd0, 3'd1, 1'b0, "fwd_setup");
        step(1'b1, 8'h20, 32'hDEAD_BEEF, 3'd5, 3'd5, 1'b0, "fwd");
        chk("fwd.const0", rd_data0, 32'hDEAD_BEEF);
        chk("fwd.const1", rd_data1, 32'hDEAD_BEEF);

        // Illegal selects: no write, error set, no ack
        step(1'b1, 8'h00, 32'hFFFF_FFFF, 3'd0, 3'd1, 1'b0, "illegal_00");
        step(1'b1, 8'h03, 32'hFFFF_FFFF, 3'd0, 3'd1, 1'b0, "illegal_03");
        step(1'b0, 8'h00, 32'd0, 3'd0, 3'd1, 1'b0, "illegal_rb");
        chk("illegal_rb.const", rd_data0, 32'hA000_0000);

        // Clear, then non-one-hot select with we=0 must not set the flag
        step(1'b0, 8'h00, 32'd0, 3'd2, 3'd3, 1'b1, "clr_alone");
        chk("clr_alone.const", {31'd0, err_sticky}, 32'd0);
        step(1'b0, 8'h03, 32'h5555_5555, 3'd0, 3'd1, 1'b0, "we0_sel03");
        // Set wins over clear
        step(1'b1, 8'hFF, 32'h7777_7777, 3'd4, 3'd6, 1'b1, "set_vs_clr");
        chk("set_vs_clr.const", {31'd0, err_sticky}, 32'd1);

        // Mixed traffic
        for (int n = 0; n < 24; n++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            step(1'($urandom), s, $urandom, 3'($urandom), 3'($urandom),
                 ($urandom_range(0, 5) == 0), "mixed");
        end
        step(1'b1, 8'h80, 32'hA000_0007, 3'd7, 3'd0, 1'b0, "pre_rst_w7");
        step(1'b1, 8'h0C, 32'h0, 3'd7, 3'd7, 1'b0, "pre_rst_err");

        // Async reset between edges during a write to register 7
        we = 1'b1; w_sel = 8'h80; w_data = 32'hCAFE_F00D;
        rd_addr0 = 3'd7; rd_addr1 = 3'd7; clr_err = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async.rd0", rd_data0, 32'd0);
        chk("async.rd1", rd_data1, 32'd0);
        chk("async.err", {31'd0, err_sticky}, 32'd0);
        chk("async.ack", {31'd0, wr_ack}, 32'd0);
        @(posedge clk);
        #2;
        we = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        mdl_err = 1'b0;
        step(1'b0, 8'h00, 32'd0, 3'd7, 3'd0, 1'b0, "post_rst");
        chk("post_rst.reg7", rd_data0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
